// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding and
// frame/oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int IDX_W      = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_os_tick.sv
// Baud-rate divider: emits a one-cycle tick every DIV clocks (16 ticks per
// bit). A restart pulse realigns the phase to the detected start edge.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int DIV = 325
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q;

  // Free-running divider, cleared on restart and on wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (restart || (div_q == LAST)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // A restart cycle never produces a tick so the new phase starts cleanly.
  assign tick = (div_q == LAST) && !restart;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with optional parity, a one-byte holding
// register with valid/ack handshake, and sticky overrun reporting.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int   DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int   DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam bit   HAS_PAR = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 prev_q;
  logic [1:0]           prime_q;
  logic                 fall;
  logic                 restart;
  logic                 tick;
  logic                 mid;
  logic                 stop_mid;
  uart_state_e          state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_pend_q;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 ovr_q;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer plus edge history; falling edges are ignored until
  // both the synchronizer and the history flop hold post-reset line samples,
  // so a line that is low at reset release does not fake a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      prime_q <= 2'd0;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      prev_q <= rx_s;
      if (prime_q != 2'd3) begin
        prime_q <= prime_q + 1'b1;
      end
    end
  end

  assign fall     = (prime_q == 2'd3) && prev_q && !rx_s;
  assign restart  = (state_q == ST_IDLE) && fall;
  assign mid      = tick && (tick_cnt_q == TICK_W'(MID_TICK));
  assign stop_mid = (state_q == ST_STOP) && mid;

  uart_os_tick #(
    .DIV(DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Frame FSM: mid-bit sampling of start, data (LSB first), parity and stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
    end else begin
      if (tick) begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q     <= ST_START;
            tick_cnt_q  <= '0;
            idx_q       <= '0;
            perr_pend_q <= 1'b0;
          end
        end
        ST_START: begin
          if (mid) begin
            state_q <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (mid) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
              state_q <= HAS_PAR ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (mid) begin
            perr_pend_q <= rx_s ^ (^shift_q) ^ PAR_ODD;
            state_q     <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave at mid-stop so an immediately following start edge is seen.
          if (mid) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Holding register: load on stop sample when free (or freed this cycle),
  // otherwise drop the byte and flag overrun; ack releases a held byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (stop_mid) begin
      if (!valid_q || data_ack) begin
        data_q  <= shift_q;
        perr_q  <= perr_pend_q;
        ferr_q  <= !rx_s;
        valid_q <= 1'b1;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (valid_q && data_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the line bit rate.
REQ-003 SHALL have parameter PARITY_EN, default 1, meaning a parity bit is present after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port data_ack, input, 1 bit: the consumer accepts the held byte.
REQ-009 SHALL have port data_out, output, 8 bits: the received byte.
REQ-010 SHALL have port data_valid, output, 1 bit: data_out and the error flags are valid.
REQ-011 SHALL have port parity_err, output, 1 bit: the held byte failed the parity check.
REQ-012 SHALL have port frame_err, output, 1 bit: the stop bit was sampled low.
REQ-013 SHALL have port overrun, output, 1 bit: sticky; a byte was lost while data_valid was pending.
REQ-014 SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.

Function
REQ-015 SHALL pass rx_in through a 2-flop synchronizer before any use; the added latency is 2 clocks.
REQ-016 SHALL generate a one-cycle tick every DIV = CLK_FREQ/(BAUD*16) clocks, integer floor (325 at the defaults); 16 ticks make one bit time.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; only PARITY is skipped, when PARITY_EN=0.
REQ-018 IDLE: a synchronized high-to-low edge SHALL move the FSM to START, clear the tick counter, and restart the divider phase.
REQ-019 START: at tick 7 (mid-bit) the line SHALL be sampled; low goes to DATA, high (glitch) returns to IDLE with no flags set.
REQ-020 DATA: 8 bits SHALL be sampled LSB first, one every 16 ticks at mid-bit, into a shift register with a 3-bit index; after index 7 the FSM goes to PARITY or STOP.
REQ-021 PARITY: the received bit SHALL be compared with XOR(data) ^ PARITY_ODD; a mismatch sets the pending parity error.
REQ-022 STOP: at mid-bit the line SHALL be sampled; low sets the pending frame error. In the same cycle the FSM SHALL return to IDLE, so the next start edge is accepted immediately.
REQ-023 At the STOP sample, with data_valid low, the block SHALL load data_out and both error flags and raise data_valid.
REQ-024 data_valid SHALL stay high, with data_out stable, until a cycle in which data_ack=1; data_valid SHALL drop on the next clock.
REQ-025 At the STOP sample, with data_valid high and no data_ack in the same cycle, the block SHALL discard the new byte, leave data_out unchanged, and set overrun.
REQ-026 With data_valid high and data_ack=1 in the same cycle as a STOP sample, the new byte SHALL be loaded, data_valid SHALL stay high, and overrun SHALL NOT be set.
REQ-027 overrun SHALL be cleared only by reset.
REQ-028 data_ack SHALL be ignored while data_valid is low.
REQ-029 A framing error SHALL still deliver the byte, with frame_err=1.
REQ-030 A reception SHALL complete within 10 bit times (11 with parity) from the start edge plus 3 clocks.

Reset
REQ-031 While reset is high, the FSM SHALL be in IDLE, all counters and the shift register SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-032 While reset is high, data_out=8'h00, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-033 A reset in mid-frame SHALL abandon the frame with no output; after release, the FSM SHALL resynchronize only on a new falling edge.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state encoding, the constant DATA_BITS=8, the constant OVERSAMPLE=16, and the mid-bit index 7.
REQ-035 The divider and tick generator SHALL be a sub-module named uart_os_tick, with clock, reset, a restart input, and a tick output.

Verification
REQ-036 Defaults, frame 0x55 even parity (parity bit 0), valid stop -> data_valid=1, data_out=8'h55, both error flags 0, held until data_ack.
REQ-037 Frame 0xA3 with the parity bit inverted -> data_out=8'hA3, parity_err=1, frame_err=0.
REQ-038 Frame 0x0F with stop bit low -> data_out=8'h0F, frame_err=1; back-to-back frame 0x10 -> received correctly.
REQ-039 0.3-bit-time low pulse on idle rx_in -> no data_valid, busy returns to 0 by mid-bit.
REQ-040 Two frames, 0x11 then 0x22, with no data_ack -> data_out stays 8'h11 and overrun=1; a third frame with data_ack pulsed at its stop sample -> data_out=8'h33, overrun stays 1.
REQ-041 reset asserted during data bit 4 of 0xC6, then released; then frame 0x7E -> only 8'h7E is delivered.
